// File: rtl/sat_narrow_16b_11b.sv
// sat_narrow_16b_11b: streaming 16b -> 11b signed narrowing unit.
// Two-stage elastic pipeline with valid/ready on both sides. It flags words
// that fall outside the 11b signed range and keeps a sticky flag and a
// saturating count of overflow words that leave the unit.
//
// Build option: define SAT_NARROW_SATURATE_EN to clamp overflow words to
// +1023 or -1024. Without it, overflow words are truncated (wrap-around).
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready is combinational)
//   in_data[15:0]        two's-complement source value
//   out_valid/out_ready  downstream handshake
//   out_data[10:0]       narrowed value
//   out_ovf              the current output word was out of range
//   clr_ovf              clear ovf_sticky and ovf_count
//   ovf_sticky           an overflow word has been delivered since reset or clear
//   ovf_count[CNT_W-1:0] number of overflow words delivered (saturating)
module sat_narrow_16b_11b #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_ovf,
  input  logic             clr_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam int unsigned IN_W  = 16;
  localparam int unsigned OUT_W = 11;
  // The upper bits plus the new sign bit must all match the source sign.
  localparam int unsigned HI_W  = IN_W - OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [IN_W-1:0]  s1_data;
  logic             s1_fits;
  logic [OUT_W-1:0] s1_narrow;
  logic             s2_free;
  logic             in_xfer;
  logic             out_xfer;
  logic             ovf_evt;

  // S2 can take a word when it is empty or its word leaves this cycle.
  assign s2_free  = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_free;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign ovf_evt  = out_xfer & out_ovf;

  // Range check and narrowing of the S1 word.
  always_comb begin
    s1_fits   = (s1_data[IN_W-1 -: HI_W] == {HI_W{s1_data[IN_W-1]}});
    s1_narrow = s1_data[OUT_W-1:0];
`ifdef SAT_NARROW_SATURATE_EN
    if (!s1_fits) begin
      s1_narrow = s1_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                  : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  // Stage 1: registers the raw source word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      // in_ready means S1 is either empty or moving on, so it is refilled.
      if (in_ready) s1_valid <= in_valid;
      if (in_xfer)  s1_data  <= in_data;
    end
  end

  // Stage 2: output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= s1_narrow;
        out_ovf  <= ~s1_fits;
      end
    end
  end

  // Overflow status; a new event takes precedence over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else if (ovf_evt) begin
      ovf_sticky <= 1'b1;
      if (clr_ovf) begin
        ovf_count <= CNT_W'(1);
      end else if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_W'(1);
      end
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end
  end

endmodule

// File: tb/tb_sat_narrow_16b_11b.sv
// Self-checking bench for sat_narrow_16b_11b: table vectors, directed
// corner sequences and random traffic against a range-based reference model.
module tb_sat_narrow_16b_11b;

  localparam int unsigned CNT_W   = 8;
  localparam int          CNT_TOP = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [10:0]       out_data;
  logic              out_ovf;
  logic              clr_ovf;
  logic              ovf_sticky;
  logic [CNT_W-1:0]  ovf_count;

  sat_narrow_16b_11b #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .clr_ovf    (clr_ovf),
    .ovf_sticky (ovf_sticky),
    .ovf_count  (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] d;
    logic        o;
    int          t;   // accept cycle (expected) or latency (observed)
  } rec_t;

  typedef struct {
    logic [15:0] din;
    logic [10:0] dout;
    logic        ovf;
  } vec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  vec_t tbl[6];

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;
  int m_cnt = 0;
  logic m_st = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  // Reference: value range decides fit; overflow policy depends on the build.
  function automatic rec_t model(input logic [15:0] d, input int t);
    rec_t r;
    int v;
    v = int'($signed(d));
    r.t = t;
    if (v >= -1024 && v <= 1023) begin
      r.d = d[10:0];
      r.o = 1'b0;
    end else begin
      r.o = 1'b1;
`ifdef SAT_NARROW_SATURATE_EN
      r.d = (v > 0) ? 11'd1023 : 11'h400;
`else
      r.d = d[10:0];
`endif
    end
    return r;
  endfunction

  // One clock cycle: drive, sample at negedge, update model, step past edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r,
                     input logic c, output logic acc);
    rec_t e;
    logic ev;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clr_ovf   = c;
    @(negedge clk);
    acc = in_valid & in_ready & ~rst;
    ev  = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_st  = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL sb_spurious: got word %0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(out_data), 32'(e.d));
          chk("sb_ovf", 32'(out_ovf), 32'(e.o));
          obs_q.push_back('{d: out_data, o: out_ovf, t: cyc_n - e.t});
          ev = e.o;
        end
      end
      if (acc) exp_q.push_back(model(in_data, cyc_n));
      if (ev) begin
        m_st  = 1'b1;
        m_cnt = c ? 1 : ((m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP);
      end else if (c) begin
        m_st  = 1'b0;
        m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_st));
  endtask

  task automatic idle(input int n, input logic r);
    logic a;
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, r, 1'b0, a);
  endtask

  initial begin
    logic a;
    int nacc;
    logic [15:0] v;
    logic [10:0] x;

    tbl[0] = '{din: 16'h0000, dout: 11'h000, ovf: 1'b0};
    tbl[1] = '{din: 16'h03FF, dout: 11'h3FF, ovf: 1'b0};
    tbl[2] = '{din: 16'hFC00, dout: 11'h400, ovf: 1'b0};
    tbl[3] = '{din: 16'hFFFF, dout: 11'h7FF, ovf: 1'b0};
`ifdef SAT_NARROW_SATURATE_EN
    tbl[4] = '{din: 16'h0400, dout: 11'h3FF, ovf: 1'b1};
    tbl[5] = '{din: 16'hFBFF, dout: 11'h400, ovf: 1'b1};
`else
    tbl[4] = '{din: 16'h0400, dout: 11'h400, ovf: 1'b1};
    tbl[5] = '{din: 16'hFBFF, dout: 11'h3FF, ovf: 1'b1};
`endif

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk); #1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, a);

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_count", 32'(ovf_count), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Table vectors streamed back to back
    obs_q.delete();
    for (int i = 0; i < 6; i++) cyc(1'b1, tbl[i].din, 1'b1, 1'b0, a);
    idle(3, 1'b1);
    chk("tbl_count_words", 32'(obs_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      chk($sformatf("tbl_data_%0d", i), 32'(obs_q[i].d), 32'(tbl[i].dout));
      chk($sformatf("tbl_ovf_%0d", i), 32'(obs_q[i].o), 32'(tbl[i].ovf));
      chk($sformatf("tbl_lat_%0d", i), 32'(obs_q[i].t), 32'd2);
      if (!tbl[i].ovf)
        chk($sformatf("tbl_sext_%0d", i), 32'({{5{obs_q[i].d[10]}}, obs_q[i].d}),
            32'(tbl[i].din));
    end
    chk("tbl_ovf_count", 32'(ovf_count), 32'd2);
    chk("tbl_ovf_sticky", 32'(ovf_sticky), 32'd1);

    // Backpressure: out_ready low for 5 cycles
    obs_q.delete();
    v = 16'd1;
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, v, 1'b0, 1'b0, a);
      if (a) begin v++; nacc++; end
      if (i >= 1) begin
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_data", 32'(out_data), 32'd1);
      end
    end
    chk("bp_accepts", 32'(nacc), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, v, 1'b1, 1'b0, a);
      if (a) v++;
    end
    idle(3, 1'b1);
    chk("bp_words", 32'(obs_q.size()), 32'(int'(v) - 1));
    for (int k = 0; k < obs_q.size(); k++)
      chk($sformatf("bp_seq_%0d", k), 32'(obs_q[k].d), 32'(k + 1));

    // Counter saturation and clear behaviour
    for (int i = 0; i < 300; i++) cyc(1'b1, 16'h7FFF, 1'b1, 1'b0, a);
    idle(4, 1'b1);
    chk("sat_count", 32'(ovf_count), 32'(CNT_TOP));
    chk("sat_sticky", 32'(ovf_sticky), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, a);
    chk("clr_count", 32'(ovf_count), 32'd0);
    chk("clr_sticky", 32'(ovf_sticky), 32'd0);
    cyc(1'b1, 16'h7FFF, 1'b0, 1'b0, a);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    cyc(1'b0, 16'h0, 1'b1, 1'b1, a);
    chk("clr_evt_count", 32'(ovf_count), 32'd1);
    chk("clr_evt_sticky", 32'(ovf_sticky), 32'd1);

    // Reset with both stages full and count = 3
    cyc(1'b0, 16'h0, 1'b1, 1'b1, a);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h8000, 1'b1, 1'b0, a);
    idle(3, 1'b1);
    cyc(1'b1, 16'h0001, 1'b0, 1'b0, a);
    cyc(1'b1, 16'h0002, 1'b0, 1'b0, a);
    chk("pre_rst_count", 32'(ovf_count), 32'd3);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    rst = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0, a);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(ovf_count), 32'd0);
    chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    obs_q.delete();
    cyc(1'b1, 16'h0123, 1'b1, 1'b0, a);
    idle(3, 1'b1);
    chk("post_rst_words", 32'(obs_q.size()), 32'd1);
    if (obs_q.size() > 0) begin
      chk("post_rst_data", 32'(obs_q[0].d), 32'h123);
      chk("post_rst_lat", 32'(obs_q[0].t), 32'd2);
    end

    // Random traffic against the reference model
    for (int i = 0; i < 320; i++) begin
      x = 11'($urandom);
      if ($urandom_range(0, 1) == 1) v = 16'($urandom);
      else v = {{5{x[10]}}, x};
      cyc($urandom_range(0, 3) != 0, v, $urandom_range(0, 3) != 0,
          $urandom_range(0, 15) == 0, a);
    end
    idle(6, 1'b1);
    chk("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
